// File: rtl/pll_controller_param.sv
// pll_controller_param: DCO trim controller; measures osc half-periods against div and steps a
// saturating trim value with deadband, lock, stall detection and manual load.
module pll_controller_param #(
    parameter int DIV_W      = 5,
    parameter int TVAL_W     = 7,
    parameter int TRIM_W     = 26,
    parameter int TRIM_SHIFT = 2,
    parameter int COUNT_W    = 8,
    parameter int DEADBAND   = 0,
    parameter int LOCK_CNT   = 8,
    parameter int TVAL_INIT  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              osc,
    input  logic [DIV_W-1:0]  div,
    input  logic              enable,
    input  logic              load,
    input  logic [TVAL_W-1:0] load_val,
    output logic [TVAL_W-1:0] tval,
    output logic [TRIM_W-1:0] trim,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              stall
);
    localparam int CW = (COUNT_W > DIV_W ? COUNT_W : DIV_W) + 2;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [TVAL_W-1:0] TMAX = {TVAL_W{1'b1}};
    localparam logic [TVAL_W-1:0] TINIT = TVAL_W'(TVAL_INIT);
    localparam logic [CW-1:0] DB = CW'(DEADBAND);
    localparam logic [LW-1:0] LMAX = LW'(LOCK_CNT);

    function automatic logic [TRIM_W-1:0] enc(input logic [TVAL_W-1:0] v);
        logic [TVAL_W-1:0] sh;
        logic [TRIM_W-1:0] r;
        sh = v >> TRIM_SHIFT;
        for (int i = 0; i < TRIM_W; i++) r[i] = int'(sh) > i;
        return r;
    endfunction

    logic s1, s2, hist, first, osc_edge, stall_hit;
    logic pv, pslow, pfast, pzero, slow, fast;
    logic [COUNT_W-1:0] cnt, cnt_inc;
    logic [CW-1:0] period, d, lo, hi;
    logic [LW-1:0] lcnt, lcnt_nx;
    logic [TVAL_W-1:0] tval_nx;

    assign osc_edge  = s2 ^ hist;
    assign cnt_inc   = cnt + 1'b1;
    // the cycle that would bring cnt to all-ones is the timeout, so it repeats every 2^COUNT_W-1 cycles
    assign stall_hit = ~osc_edge & (&cnt_inc);
    assign period    = CW'(cnt) + 1'b1;
    assign d         = CW'(div);
    assign lo        = d > DB ? d - DB : '0;
    assign hi        = d + DB;
    assign slow      = period > hi;
    assign fast      = period < lo;
    assign locked    = lcnt == LMAX;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {s1, s2, hist} <= '0;
            cnt   <= '0;
            first <= 1'b1;
            stall <= 1'b0;
            {pv, pslow, pfast, pzero} <= '0;
        end else begin
            s1    <= osc;
            s2    <= s1;
            hist  <= s2;
            cnt   <= (osc_edge | stall_hit) ? '0 : cnt_inc;
            first <= stall_hit ? 1'b1 : osc_edge ? 1'b0 : first;
            stall <= stall_hit ? 1'b1 : osc_edge ? 1'b0 : stall;
            pv    <= (osc_edge & ~first) | stall_hit;
            pslow <= stall_hit | slow;
            pfast <= ~stall_hit & fast;
            pzero <= ~stall_hit & (div == '0);
        end
    end

    // step decisions are registered on the edge cycle and applied here one cycle later
    always_comb begin
        tval_nx = tval;
        lcnt_nx = lcnt;
        if (load) begin
            tval_nx = load_val;
            lcnt_nx = '0;
        end else if (enable && pv) begin
            if (pzero) lcnt_nx = '0;
            else if (pslow) begin
                tval_nx = tval == TMAX ? tval : tval + 1'b1;
                lcnt_nx = '0;
            end else if (pfast) begin
                tval_nx = tval == '0 ? tval : tval - 1'b1;
                lcnt_nx = '0;
            end else lcnt_nx = lcnt == LMAX ? lcnt : lcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tval   <= TINIT;
            lcnt   <= '0;
            trim   <= enc(TINIT);
            sat_hi <= TINIT == TMAX;
            sat_lo <= TINIT == '0;
        end else begin
            tval   <= tval_nx;
            lcnt   <= lcnt_nx;
            trim   <= enc(tval);
            sat_hi <= tval == TMAX;
            sat_lo <= tval == '0;
        end
    end
endmodule
